// File: rtl/rf_spill_fill_mem.sv
// rf_spill_fill_mem: LIFO backing stack for spilled register windows, streams the most recent window back on FILL.
module rf_spill_fill_mem #(
  parameter int NBITS = 64,
  parameter int N = 3,
  parameter int STACK_WINDOWS = 8,
  localparam int WPW = 2 * N,
  localparam int DEPTH_W = STACK_WINDOWS * WPW,
  localparam int CW = $clog2(DEPTH_W + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SPILL,
  input  logic [NBITS-1:0] MEM_BUS,
  input  logic             FILL,
  output logic [NBITS-1:0] MEM_BUSread,
  output logic             FILL_VALID,
  output logic             BUSY,
  output logic [CW-1:0]    STACK_CNT,
  output logic             OVERFLOW,
  output logic             UNDERFLOW,
  output logic             PROTO_ERR
);
  localparam int AW = $clog2(DEPTH_W);
  localparam int SW = $clog2(WPW);
  localparam int FW = $clog2(WPW + 1);
  typedef enum logic {IDLE, FILLING} state_t;
  state_t state;
  logic [NBITS-1:0] mem [DEPTH_W];
  logic [SW-1:0] sc;
  logic [FW-1:0] fc;
  logic [CW-1:0] top;
  logic push;
  assign top = STACK_CNT - 1'b1;
  assign push = state == IDLE && SPILL && STACK_CNT < CW'(DEPTH_W);
  always_ff @(posedge CLK)
    if (push) mem[STACK_CNT[AW-1:0]] <= MEM_BUS;
  // The accepting FILL edge already issues the first read, so fc counts words issued and
  // one extra FILLING cycle (fc==WPW) presents the last word before returning to IDLE.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      MEM_BUSread <= '0;
      FILL_VALID  <= 1'b0;
      BUSY        <= 1'b0;
      STACK_CNT   <= '0;
      OVERFLOW    <= 1'b0;
      UNDERFLOW   <= 1'b0;
      PROTO_ERR   <= 1'b0;
      sc          <= '0;
      fc          <= '0;
    end else if (state == IDLE) begin
      FILL_VALID <= 1'b0;
      BUSY       <= 1'b0;
      if (SPILL) begin
        if (push) begin
          STACK_CNT <= STACK_CNT + 1'b1;
          sc        <= sc == SW'(WPW - 1) ? '0 : sc + 1'b1;
        end else OVERFLOW <= 1'b1;
        if (FILL) PROTO_ERR <= 1'b1;
      end else if (FILL) begin
        if (sc != '0) PROTO_ERR <= 1'b1;
        else if (STACK_CNT < CW'(WPW)) UNDERFLOW <= 1'b1;
        else begin
          state       <= FILLING;
          BUSY        <= 1'b1;
          FILL_VALID  <= 1'b1;
          MEM_BUSread <= mem[top[AW-1:0]];
          STACK_CNT   <= top;
          fc          <= FW'(1);
        end
      end
    end else begin
      if (SPILL || FILL) PROTO_ERR <= 1'b1;
      if (fc == FW'(WPW)) begin
        state      <= IDLE;
        BUSY       <= 1'b0;
        FILL_VALID <= 1'b0;
        fc         <= '0;
      end else begin
        MEM_BUSread <= mem[top[AW-1:0]];
        STACK_CNT   <= top;
        fc          <= fc + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rf_spill_fill_mem.sv
// tb_rf_spill_fill_mem: directed test-plan scenarios plus random traffic against a queue-based stack model.
module tb_rf_spill_fill_mem;
  localparam int WPW = 6;
  localparam int DEPTH = 48;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        SPILL = 1'b0;
  logic        FILL = 1'b0;
  logic [63:0] MEM_BUS = '0;
  logic [63:0] MEM_BUSread;
  logic        FILL_VALID, BUSY, OVERFLOW, UNDERFLOW, PROTO_ERR;
  logic [5:0]  STACK_CNT;
  int vectors = 0;
  int miscompares = 0;
  logic [63:0] q[$];
  int sc;
  bit m_ovf, m_udf, m_perr;
  logic [63:0] last_word;

  rf_spill_fill_mem dut (
    .CLK(CLK), .RESET(RESET), .SPILL(SPILL), .MEM_BUS(MEM_BUS), .FILL(FILL),
    .MEM_BUSread(MEM_BUSread), .FILL_VALID(FILL_VALID), .BUSY(BUSY), .STACK_CNT(STACK_CNT),
    .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW), .PROTO_ERR(PROTO_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, " cnt"}, 64'(STACK_CNT), 64'(q.size()));
    check({tag, " ovf"}, 64'(OVERFLOW), 64'(m_ovf));
    check({tag, " udf"}, 64'(UNDERFLOW), 64'(m_udf));
    check({tag, " perr"}, 64'(PROTO_ERR), 64'(m_perr));
  endtask

  task automatic do_reset;
    RESET = 1'b1;
    #1;
    q.delete();
    sc = 0;
    m_ovf = 0;
    m_udf = 0;
    m_perr = 0;
    check("rst valid", 64'(FILL_VALID), 64'd0);
    check("rst busy", 64'(BUSY), 64'd0);
    check_state("rst");
    cyc();
    RESET = 1'b0;
  endtask

  task automatic push(input logic [63:0] w, input bit with_fill = 0);
    SPILL = 1'b1;
    MEM_BUS = w;
    FILL = with_fill;
    cyc();
    SPILL = 1'b0;
    FILL = 1'b0;
    if (q.size() < DEPTH) begin
      q.push_back(w);
      sc = (sc + 1) % WPW;
    end else m_ovf = 1;
    if (with_fill) m_perr = 1;
    check_state("push");
  endtask

  task automatic fill(input int inject = -1);
    logic [63:0] exp;
    bit acc;
    FILL = 1'b1;
    cyc();
    FILL = 1'b0;
    acc = sc == 0 && q.size() >= WPW;
    if (sc != 0) m_perr = 1;
    else if (q.size() < WPW) m_udf = 1;
    if (!acc) begin
      check("nofill valid", 64'(FILL_VALID), 64'd0);
      check("nofill busy", 64'(BUSY), 64'd0);
      check_state("nofill");
      return;
    end
    for (int i = 0; i < WPW; i++) begin
      exp = q.pop_back();
      check("burst valid", 64'(FILL_VALID), 64'd1);
      check("burst busy", 64'(BUSY), 64'd1);
      check("burst data", MEM_BUSread, exp);
      check("burst cnt", 64'(STACK_CNT), 64'(q.size()));
      last_word = exp;
      if (i == inject) begin
        SPILL = 1'b1;
        MEM_BUS = 64'hBEEF;
        m_perr = 1;
      end
      cyc();
      SPILL = 1'b0;
    end
    check("end valid", 64'(FILL_VALID), 64'd0);
    check("end busy", 64'(BUSY), 64'd0);
    check("end hold", MEM_BUSread, last_word);
    check_state("end");
  endtask

  initial begin
    do_reset();
    check("rst data", MEM_BUSread, 64'd0);
    for (int i = 0; i < 6; i++) push(64'h10 + 64'(i));
    fill();
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(64'(i));
    push(64'hDEAD);
    fill();
    do_reset();
    fill();
    do_reset();
    for (int i = 0; i < 4; i++) push(64'h100 + 64'(i));
    fill();
    push(64'h200);
    push(64'h201);
    fill();
    do_reset();
    for (int i = 0; i < 12; i++) push(64'h300 + 64'(i));
    fill(3);
    do_reset();
    for (int i = 0; i < 6; i++) push(64'h400 + 64'(i));
    FILL = 1'b1;
    cyc();
    FILL = 1'b0;
    cyc();
    check("pre-rst valid", 64'(FILL_VALID), 64'd1);
    do_reset();
    fill();
    do_reset();
    for (int it = 0; it < 300; it++) begin
      int r;
      int k;
      r = int'($urandom_range(0, 9));
      if (r <= 3) begin
        k = int'($urandom_range(1, 6));
        for (int j = 0; j < k; j++) push({$urandom, $urandom});
      end else if (r <= 5) begin
        k = WPW - sc;
        for (int j = 0; j < k; j++) push({$urandom, $urandom});
      end else if (r <= 8) fill();
      else push({$urandom, $urandom}, 1'b1);
      if (it % 100 == 99) do_reset();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
